// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared types and constants for the multi-cycle sequencer
package rv_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        TRAP
    } stateT;

    typedef enum logic [2:0] {
        CLS_ILL,
        CLS_R,
        CLS_I,
        CLS_LD,
        CLS_ST,
        CLS_BR
    } instrClassT;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_LDST  = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_SUB   = 2'b11;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    function automatic instrClassT decodeClass(input logic [6:0] op);
        case (op)
            OP_R:    return CLS_R;
            OP_I:    return CLS_I;
            OP_LD:   return CLS_LD;
            OP_ST:   return CLS_ST;
            OP_BR:   return CLS_BR;
            default: return CLS_ILL;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts stalled memory cycles and flags a timeout
module mem_wait_timer #(
    parameter int WAIT_LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic reqActive,
    input  logic memReady,
    output logic timeout,
    output logic waiting
);

    localparam int CW = (WAIT_LIMIT > 2) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_LIMIT - 1);

    logic [CW-1:0] waitCnt;

    // Saturates at LAST; the controller leaves the request state on that edge anyway.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waitCnt <= '0;
        end else if (!reqActive || memReady) begin
            waitCnt <= '0;
        end else if (waitCnt != LAST) begin
            waitCnt <= waitCnt + CW'(1);
        end
    end

    assign timeout = reqActive && !memReady && (waitCnt == LAST);
    assign waiting = (waitCnt != '0);

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - FETCH/DECODE/EXEC/MEM/WB sequencer with trap handling
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Run,
    input  logic [6:0]       Opcode,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IorD,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCSrc,
    output logic             ALUSrc,
    output logic [1:0]       ALUOp,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             Retire,
    output logic [CNT_W-1:0] RetireCnt,
    output logic             Trap,
    output logic [1:0]       TrapCause
);

    stateT      state;
    instrClassT cls;
    logic [1:0] trapCause;
    logic       fetchWaiting;
    logic       fetchReq;
    logic       memReq;
    logic       timeout;
    logic       retireNow;

    // A fetch that has already stalled stays requested even if Run drops.
    assign fetchReq  = (state == FETCH) && (Run || fetchWaiting);
    assign memReq    = (state == MEM);
    assign retireNow = (state == WB)
                    || ((state == EXEC) && (cls == CLS_BR))
                    || ((state == MEM) && (cls == CLS_ST) && MemReady);

    mem_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .reqActive(fetchReq || memReq),
        .memReady (MemReady),
        .timeout  (timeout),
        .waiting  (fetchWaiting)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            cls       <= CLS_ILL;
            trapCause <= CAUSE_NONE;
            RetireCnt <= '0;
        end else begin
            if (retireNow) begin
                RetireCnt <= RetireCnt + CNT_W'(1);
            end
            case (state)
                FETCH: begin
                    if (timeout) begin
                        state     <= TRAP;
                        trapCause <= CAUSE_TIMEOUT;
                    end else if (fetchReq && MemReady) begin
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    cls <= decodeClass(Opcode);
                    if (decodeClass(Opcode) == CLS_ILL) begin
                        state     <= TRAP;
                        trapCause <= CAUSE_ILLEGAL;
                    end else begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    case (cls)
                        CLS_BR:         state <= FETCH;
                        CLS_LD, CLS_ST: state <= MEM;
                        default:        state <= WB;
                    endcase
                end
                MEM: begin
                    if (timeout) begin
                        state     <= TRAP;
                        trapCause <= CAUSE_TIMEOUT;
                    end else if (MemReady) begin
                        state <= (cls == CLS_LD) ? WB : FETCH;
                    end
                end
                WB:      state <= FETCH;
                TRAP:    state <= TRAP;
                default: state <= FETCH;
            endcase
        end
    end

    // Gated by rst_n so an in-flight request vanishes the moment reset asserts.
    always_comb begin
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IorD      = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        PCSrc     = 1'b0;
        ALUSrc    = 1'b0;
        ALUOp     = ALU_ADD;
        MemtoReg  = 1'b0;
        RegWrite  = 1'b0;
        Retire    = 1'b0;
        Trap      = 1'b0;
        TrapCause = CAUSE_NONE;
        if (rst_n) begin
            Retire    = retireNow;
            TrapCause = trapCause;
            case (state)
                FETCH: begin
                    MemRead = fetchReq;
                    IRWrite = fetchReq && MemReady;
                    PCWrite = fetchReq && MemReady;
                end
                EXEC: begin
                    case (cls)
                        CLS_R: ALUOp = ALU_RTYPE;
                        CLS_I: ALUSrc = 1'b1;
                        CLS_LD, CLS_ST: begin
                            ALUOp  = ALU_LDST;
                            ALUSrc = 1'b1;
                        end
                        CLS_BR: begin
                            ALUOp   = ALU_SUB;
                            PCWrite = Zero;
                            PCSrc   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                MEM: begin
                    IorD     = 1'b1;
                    ALUOp    = ALU_LDST;
                    ALUSrc   = 1'b1;
                    MemRead  = (cls == CLS_LD);
                    MemWrite = (cls == CLS_ST);
                end
                WB: begin
                    RegWrite = 1'b1;
                    MemtoReg = (cls == CLS_LD);
                end
                TRAP:    Trap = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Run = 1'b0;
    logic [6:0]  Opcode = 7'd0;
    logic        Zero = 1'b0;
    logic        MemReady = 1'b0;
    logic        MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSrc, ALUSrc;
    logic [1:0]  ALUOp;
    logic        MemtoReg, RegWrite, Retire, Trap;
    logic [31:0] RetireCnt;
    logic [1:0]  TrapCause;

    always #5 clk = ~clk;

    multicycle_ctrl #(.WAIT_LIMIT(16), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .Run(Run), .Opcode(Opcode), .Zero(Zero),
        .MemReady(MemReady), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .ALUSrc(ALUSrc),
        .ALUOp(ALUOp), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .Retire(Retire),
        .RetireCnt(RetireCnt), .Trap(Trap), .TrapCause(TrapCause)
    );

    // {MemRead,MemWrite,IorD,IRWrite,PCWrite,PCSrc,ALUSrc,ALUOp,MemtoReg,RegWrite,Retire,Trap,TrapCause}
    wire [14:0] actVec = {MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSrc, ALUSrc,
                          ALUOp, MemtoReg, RegWrite, Retire, Trap, TrapCause};

    localparam logic [14:0] V_IDLE   = 15'd0;
    localparam logic [14:0] V_FWAIT  = 15'b1_0_0_0_0_0_0_00_0_0_0_0_00;
    localparam logic [14:0] V_FDONE  = 15'b1_0_0_1_1_0_0_00_0_0_0_0_00;
    localparam logic [14:0] V_EXR    = 15'b0_0_0_0_0_0_0_10_0_0_0_0_00;
    localparam logic [14:0] V_EXI    = 15'b0_0_0_0_0_0_1_00_0_0_0_0_00;
    localparam logic [14:0] V_EXLS   = 15'b0_0_0_0_0_0_1_01_0_0_0_0_00;
    localparam logic [14:0] V_EXBR0  = 15'b0_0_0_0_0_1_0_11_0_0_1_0_00;
    localparam logic [14:0] V_EXBR1  = 15'b0_0_0_0_1_1_0_11_0_0_1_0_00;
    localparam logic [14:0] V_LDMEM  = 15'b1_0_1_0_0_0_1_01_0_0_0_0_00;
    localparam logic [14:0] V_STWAIT = 15'b0_1_1_0_0_0_1_01_0_0_0_0_00;
    localparam logic [14:0] V_STDONE = 15'b0_1_1_0_0_0_1_01_0_0_1_0_00;
    localparam logic [14:0] V_WBALU  = 15'b0_0_0_0_0_0_0_00_0_1_1_0_00;
    localparam logic [14:0] V_WBLD   = 15'b0_0_0_0_0_0_0_00_1_1_1_0_00;
    localparam logic [14:0] V_TRILL  = 15'b0_0_0_0_0_0_0_00_0_0_0_1_01;
    localparam logic [14:0] V_TRTO   = 15'b0_0_0_0_0_0_0_00_0_0_0_1_10;

    localparam logic [6:0] OPC_R  = 7'b0110011;
    localparam logic [6:0] OPC_I  = 7'b0010011;
    localparam logic [6:0] OPC_LD = 7'b0000011;
    localparam logic [6:0] OPC_ST = 7'b0100011;
    localparam logic [6:0] OPC_BR = 7'b1100011;

    int          total = 0;
    int          bad = 0;
    logic [14:0] expVec = 15'd0;
    logic [31:0] expCnt = 32'd0;
    logic [31:0] retired = 32'd0;
    bit          expOn = 1'b0;
    int          cycCount = 0;
    int          lastLat = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    always @(negedge clk) begin
        if (expOn) begin
            chk("outputs", {17'd0, actVec}, {17'd0, expVec});
            chk("RetireCnt", RetireCnt, expCnt);
            cycCount++;
            if (Retire) lastLat = cycCount;
        end
    end

    task automatic cyc(input logic [14:0] v, input logic mr, input logic z);
        MemReady = mr;
        Zero     = z;
        expVec   = v;
        expCnt   = retired;
        expOn    = 1'b1;
        @(posedge clk);
        #1;
        if (v[3]) retired++;
    endtask

    task automatic trapCycles(input logic [14:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            Run = rb();
            cyc(v, rb(), rb());
        end
    endtask

    // One instruction: fd/md are stall cycles before MemReady in FETCH/MEM (>=16 times out).
    task automatic runInstr(input logic [6:0] opc, input logic z, input int fd, input int md);
        Opcode   = opc;
        Run      = 1'b1;
        cycCount = 0;
        lastLat  = 0;
        for (int i = 0; i < fd && i < 16; i++) cyc(V_FWAIT, 1'b0, rb());
        if (fd >= 16) begin
            trapCycles(V_TRTO, 5);
            return;
        end
        cyc(V_FDONE, 1'b1, rb());
        Run = rb();
        cyc(V_IDLE, rb(), rb());
        if (opc == OPC_R || opc == OPC_I) begin
            cyc((opc == OPC_R) ? V_EXR : V_EXI, rb(), rb());
            cyc(V_WBALU, rb(), rb());
        end else if (opc == OPC_BR) begin
            cyc(z ? V_EXBR1 : V_EXBR0, rb(), z);
        end else if (opc == OPC_LD || opc == OPC_ST) begin
            cyc(V_EXLS, rb(), rb());
            for (int i = 0; i < md && i < 16; i++)
                cyc((opc == OPC_LD) ? V_LDMEM : V_STWAIT, 1'b0, rb());
            if (md >= 16) begin
                trapCycles(V_TRTO, 5);
                return;
            end
            cyc((opc == OPC_LD) ? V_LDMEM : V_STDONE, 1'b1, rb());
            if (opc == OPC_LD) cyc(V_WBLD, rb(), rb());
        end else begin
            trapCycles(V_TRILL, 20);
        end
    endtask

    task automatic doReset();
        expOn = 1'b0;
        Run   = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("reset outputs", {17'd0, actVec}, 32'd0);
        chk("reset RetireCnt", RetireCnt, 32'd0);
        @(posedge clk);
        #2;
        rst_n   = 1'b1;
        retired = 32'd0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        MemReady = 1'b1;
        #3;
        chk("reset outputs", {17'd0, actVec}, 32'd0);
        chk("reset RetireCnt", RetireCnt, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        Run = 1'b0;
        for (int i = 0; i < 3; i++) cyc(V_IDLE, rb(), rb());

        runInstr(OPC_R, rb(), 0, 0);
        chk("R latency", lastLat, 4);
        chk("R RetireCnt", RetireCnt, 1);
        runInstr(OPC_I, rb(), 2, 0);
        chk("I latency", lastLat, 6);
        runInstr(OPC_LD, rb(), 0, 3);
        chk("LD stalled latency", lastLat, 8);
        runInstr(OPC_ST, rb(), 0, 0);
        chk("ST latency", lastLat, 4);
        runInstr(OPC_BR, 1'b1, 0, 0);
        chk("BR taken latency", lastLat, 3);
        runInstr(OPC_BR, 1'b0, 0, 0);
        chk("BR not taken latency", lastLat, 3);
        runInstr(OPC_LD, rb(), 0, 0);
        chk("LD latency", lastLat, 5);
        chk("RetireCnt after seven", RetireCnt, 7);

        runInstr(7'b1111111, rb(), 0, 0);
        chk("illegal TrapCause", TrapCause, 2'b01);
        doReset();

        runInstr(OPC_R, rb(), 16, 0);
        chk("fetch timeout Trap", Trap, 1'b1);
        doReset();

        runInstr(OPC_R, rb(), 15, 0);
        chk("fetch limit edge latency", lastLat, 19);

        runInstr(OPC_LD, rb(), 0, 16);
        chk("mem timeout TrapCause", TrapCause, 2'b10);
        doReset();

        Opcode = OPC_ST;
        Run    = 1'b1;
        cyc(V_FDONE, 1'b1, rb());
        cyc(V_IDLE, rb(), rb());
        cyc(V_EXLS, rb(), rb());
        cyc(V_STWAIT, 1'b0, rb());
        expOn    = 1'b0;
        MemReady = 1'b0;
        #2;
        chk("store pending MemWrite", MemWrite, 1'b1);
        Run   = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("reset drops MemWrite", MemWrite, 1'b0);
        chk("reset no Retire", Retire, 1'b0);
        doReset();
        Run = 1'b0;
        for (int i = 0; i < 4; i++) cyc(V_IDLE, rb(), rb());
        expOn = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
